// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//   Bus-to-SRAM controller between the CPU memory stage and an asynchronous
//   32-bit SRAM. One request is accepted at a time through req/ready. The
//   controller sequences the SRAM strobes with configurable wait states and
//   returns read data together with a one-cycle ack pulse.
//
// Parameters
//   READ_CYCLES   cycles oe_n is held low before read data is sampled (>=1)
//   WRITE_CYCLES  cycles we_n is held low per write pulse (>=1)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       request valid; a transfer happens when req && ready
//   ready     controller idle and able to accept a request
//   we        1 = write, 0 = read
//   addr      word address
//   be        byte enables (active-high, writes only)
//   wdata     write data
//   rdata     read data, valid with ack on reads, held until the next read
//   ack       one-cycle completion pulse
//   ram_*     SRAM pins; every one of them comes straight from a register
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [19:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    inout  wire  [31:0] ram_data,
    output logic [19:0] ram_addr,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [31:0]     wdata_reg;
    logic            drive_reg;
    logic            accept;
    logic            read_done;
    logic            write_done;
    logic            ce_n_next, oe_n_next, we_n_next, drive_next;
    logic [3:0]      be_n_next;

    assign ready      = (state_reg == IDLE);
    assign accept     = req && (state_reg == IDLE);
    assign read_done  = (state_reg == RD) && (cnt_reg == '0);
    assign write_done = (state_reg == WR_HOLD);

    // The bus is only driven while a write sequence is in progress.
    assign ram_data = drive_reg ? wdata_reg : 'z;

    // Next-state logic. The wait counter is reloaded on every state entry
    // and counts down to zero, so it never wraps.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (we) begin
                        state_next = WR_SETUP;
                        cnt_next   = '0;
                    end else begin
                        state_next = RD;
                        cnt_next   = CW'(READ_CYCLES - 1);
                    end
                end
            end
            RD: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            WR_SETUP: begin
                state_next = WR_PULSE;
                cnt_next   = CW'(WRITE_CYCLES - 1);
            end
            WR_PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = WR_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            WR_HOLD: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pin values for the next cycle are decoded from state_next so that the
    // pins themselves can be registered without adding a cycle of latency.
    always_comb begin
        ce_n_next  = (state_next == IDLE);
        oe_n_next  = (state_next != RD);
        we_n_next  = (state_next != WR_PULSE);
        drive_next = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                     (state_next == WR_HOLD);
        be_n_next  = ram_be_n;
        if (accept) begin
            be_n_next = we ? ~be : 4'h0;
        end else if (state_next == IDLE) begin
            be_n_next = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_be_n  <= 4'hF;
            drive_reg <= 1'b0;
            ram_addr  <= '0;
            wdata_reg <= '0;
            rdata     <= '0;
            ack       <= 1'b0;
        end else begin
            ram_ce_n  <= ce_n_next;
            ram_oe_n  <= oe_n_next;
            ram_we_n  <= we_n_next;
            ram_be_n  <= be_n_next;
            drive_reg <= drive_next;
            ack       <= read_done || write_done;
            if (accept) begin
                ram_addr  <= addr;
                wdata_reg <= wdata;
            end
            if (read_done) begin
                rdata <= ram_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//   Two controller instances: inst 0 uses the default 2/2 wait states for the
//   directed cases, inst 1 uses READ_CYCLES=4 / WRITE_CYCLES=1 for a random
//   mixed stream. Each instance talks to a behavioural SRAM; a separate
//   reference array produces the expected read data, which is queued when a
//   request is accepted and compared when ack arrives.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int RC0 = 2, WC0 = 2;
    localparam int RC1 = 4, WC1 = 1;

    typedef struct {
        int          inst;
        int          e0;
        int          lat;
        bit          rd;
        logic [19:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        rst_n_v    [2];
    logic        req_v      [2];
    logic        we_v       [2];
    logic [19:0] addr_v     [2];
    logic [3:0]  be_v       [2];
    logic [31:0] wdata_v    [2];
    logic        ready_o    [2];
    logic        ack_o      [2];
    logic [31:0] rdata_o    [2];
    logic [19:0] ram_addr_o [2];
    logic [3:0]  ram_be_n_o [2];
    logic        ce_o       [2];
    logic        oe_o       [2];
    logic        we_n_o     [2];
    logic [31:0] bus_v      [2];

    wire  [31:0] ram_data_a;
    wire  [31:0] ram_data_b;

    logic [31:0] sram    [2][256];
    logic [31:0] ref_mem [2][256];
    sb_t         sbq[$];

    int          rcyc [2] = '{RC0, RC1};
    int          wcyc [2] = '{WC0, WC1};
    int          oe_cnt [2] = '{0, 0};
    int          we_cnt [2] = '{0, 0};
    logic [3:0]  be_seen [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl #(.READ_CYCLES(RC0), .WRITE_CYCLES(WC0)) u_dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]), .ready(ready_o[0]),
        .we(we_v[0]), .addr(addr_v[0]), .be(be_v[0]), .wdata(wdata_v[0]),
        .rdata(rdata_o[0]), .ack(ack_o[0]), .ram_data(ram_data_a),
        .ram_addr(ram_addr_o[0]), .ram_be_n(ram_be_n_o[0]), .ram_ce_n(ce_o[0]),
        .ram_oe_n(oe_o[0]), .ram_we_n(we_n_o[0])
    );

    sram_ctrl #(.READ_CYCLES(RC1), .WRITE_CYCLES(WC1)) u_dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]), .ready(ready_o[1]),
        .we(we_v[1]), .addr(addr_v[1]), .be(be_v[1]), .wdata(wdata_v[1]),
        .rdata(rdata_o[1]), .ack(ack_o[1]), .ram_data(ram_data_b),
        .ram_addr(ram_addr_o[1]), .ram_be_n(ram_be_n_o[1]), .ram_ce_n(ce_o[1]),
        .ram_oe_n(oe_o[1]), .ram_we_n(we_n_o[1])
    );

    // Behavioural asynchronous SRAMs (256 words decoded)
    assign ram_data_a = (!ce_o[0] && !oe_o[0]) ? sram[0][ram_addr_o[0][7:0]] : 'z;
    assign ram_data_b = (!ce_o[1] && !oe_o[1]) ? sram[1][ram_addr_o[1][7:0]] : 'z;
    assign bus_v[0]   = ram_data_a;
    assign bus_v[1]   = ram_data_b;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 2; i++)
                for (int a = 0; a < 256; a++)
                    sram[i][a] <= 32'h0;
            sram[0][8'h10] <= 32'hDEADBEEF;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!ce_o[i] && !we_n_o[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (!ram_be_n_o[i][b])
                            sram[i][ram_addr_o[i][7:0]][b*8 +: 8] <= bus_v[i][b*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Ack monitor / scoreboard pop, plus strobe invariants on every cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check("strobe_excl", 32'(oe_o[i] | we_n_o[i]), 32'd1);
            if (ce_o[i])
                check("idle_strobes", {30'd0, oe_o[i], we_n_o[i]}, 32'd3);
            if (!rst_n_v[i]) begin
                oe_cnt[i] = 0;
                we_cnt[i] = 0;
            end else begin
                if (!oe_o[i]) oe_cnt[i]++;
                if (!we_n_o[i]) begin
                    we_cnt[i]++;
                    be_seen[i] = ram_be_n_o[i];
                end
                if (ack_o[i]) begin
                    if (sbq.size() == 0) begin
                        check("ack_spurious", 32'd1, 32'd0);
                    end else begin
                        sb_t e;
                        e = sbq.pop_front();
                        check("ack_inst", 32'(i), 32'(e.inst));
                        check("ack_latency", 32'(cyc - e.e0), 32'(e.lat));
                        check("addr_stable", {12'd0, ram_addr_o[i]}, {12'd0, e.addr});
                        if (e.rd) begin
                            check("rdata", rdata_o[i], e.data);
                            check("oe_low_cycles", 32'(oe_cnt[i]), 32'(rcyc[i]));
                        end else begin
                            check("we_low_cycles", 32'(we_cnt[i]), 32'(wcyc[i]));
                            check("be_n", {28'd0, be_seen[i]}, {28'd0, ~e.be});
                        end
                    end
                    $display("ack inst%0d cycle %0d addr %h rdata %h", i, cyc,
                             ram_addr_o[i], rdata_o[i]);
                    oe_cnt[i] = 0;
                    we_cnt[i] = 0;
                end
            end
        end
    end

    // Drive one request and wait for acceptance; queue its expected result.
    task automatic issue(input int i, input bit w, input logic [19:0] a,
                         input logic [3:0] b, input logic [31:0] d, output int e0);
        sb_t e;
        int  n;
        @(negedge clk);
        req_v[i] = 1'b1; we_v[i] = w; addr_v[i] = a; be_v[i] = b; wdata_v[i] = d;
        n = 0;
        while (!ready_o[i]) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                check("ready_timeout", 32'd0, 32'd1);
                req_v[i] = 1'b0;
                e0 = -1;
                return;
            end
        end
        e0     = cyc + 1;
        e.inst = i; e.e0 = e0; e.rd = !w; e.addr = a; e.be = b;
        e.lat  = w ? wcyc[i] + 2 : rcyc[i];
        if (w) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) ref_mem[i][a[7:0]][k*8 +: 8] = d[k*8 +: 8];
            e.data = 32'h0;
        end else begin
            e.data = ref_mem[i][a[7:0]];
        end
        sbq.push_back(e);
        @(posedge clk);
    endtask

    task automatic drain(input int i);
        int n;
        @(negedge clk);
        req_v[i] = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int e0_w, e0_r, e0_x;
        for (int i = 0; i < 2; i++) begin
            rst_n_v[i] = 1'b0; req_v[i] = 1'b0; we_v[i] = 1'b0;
            addr_v[i] = '0; be_v[i] = '0; wdata_v[i] = '0;
            for (int a = 0; a < 256; a++) ref_mem[i][a] = 32'h0;
        end
        ref_mem[0][8'h10] = 32'hDEADBEEF;

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(ready_o[i]), 32'd1);
            check("rst_ack", 32'(ack_o[i]), 32'd0);
            check("rst_rdata", rdata_o[i], 32'd0);
            check("rst_addr", {12'd0, ram_addr_o[i]}, 32'd0);
            check("rst_be_n", {28'd0, ram_be_n_o[i]}, 32'hF);
            check("rst_strobes", {29'd0, ce_o[i], oe_o[i], we_n_o[i]}, 32'd7);
        end
        rst_n_v[0] = 1'b1; rst_n_v[1] = 1'b1;

        // Preloaded read
        issue(0, 1'b0, 20'h00010, 4'h0, 32'h0, e0_x);
        drain(0);
        // Byte-masked write then read back (only byte 1 changes)
        issue(0, 1'b1, 20'h00020, 4'b0010, 32'h12345678, e0_x);
        issue(0, 1'b0, 20'h00020, 4'h0, 32'h0, e0_x);
        drain(0);
        check("byte1_only", ref_mem[0][8'h20], 32'h00005600);
        // Read issued in the ack cycle of a write: no idle gap
        issue(0, 1'b1, 20'h00040, 4'hF, 32'hAABBCCDD, e0_w);
        issue(0, 1'b0, 20'h00040, 4'h0, 32'h0, e0_r);
        drain(0);
        check("b2b_accept", 32'(e0_r - e0_w), 32'(WC0 + 3));
        // be=0000 write runs the whole sequence and changes nothing
        issue(0, 1'b1, 20'h00010, 4'h0, 32'h11111111, e0_x);
        issue(0, 1'b0, 20'h00010, 4'h0, 32'h0, e0_x);
        drain(0);

        // Reset during the write pulse aborts immediately
        issue(0, 1'b1, 20'h00030, 4'hF, 32'hCAFEF00D, e0_x);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (we_n_o[0] && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("reach_wr_pulse", 32'(we_n_o[0]), 32'd0);
        end
        req_v[0] = 1'b0;
        rst_n_v[0] = 1'b0;
        sbq.delete();
        #1;
        check("abort_we_n", 32'(we_n_o[0]), 32'd1);
        check("abort_ce_n", 32'(ce_o[0]), 32'd1);
        check("abort_ack", 32'(ack_o[0]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_ack_hold", 32'(ack_o[0]), 32'd0);
        end
        rst_n_v[0] = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_o[0]), 32'd1);
        check("post_rst_rdata", rdata_o[0], 32'd0);

        // Random mixed stream on the 4/1 instance
        for (int k = 0; k < 1000; k++) begin
            issue(1, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom, e0_x);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_v[1] = 1'b0;
            end
        end
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
